seven_seg_scan: RTL and testbench

- Output-side display driver for the board's 4-digit, common-anode, multiplexed seven-segment display.
- Switch-input logic produces values; this block is the path back out to the operator.
- Captures a 16-bit value, shows it as 4 hex digits, and time-multiplexes anodes with a refresh counter.
- Inserts a blanking interval at the start of each digit slot to suppress ghosting.

---
 rtl/seven_seg_scan_if.sv | 21 ++
 rtl/seven_seg_scan.sv | 101 ++++++++++
 tb/tb_seven_seg_scan.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_if.sv
// Data and display signals between the value source and the
// 4-digit seven-segment scan driver.
interface seven_seg_scan_if;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    modport master (
        output value, load, dp_in, blank,
        input  seg, dp, an
    );

    modport slave (
        input  value, load, dp_in, blank,
        output seg, dp, an
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed driver for a 4-digit common-anode hex display.
// Each digit slot starts with a short all-anodes-off interval to hide ghosting.
module seven_seg_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic            clk,
    input  logic            rst,
    seven_seg_scan_if.slave bus
);
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       idx_reg, idx_next;
    logic [15:0]      shadow_val_reg, shadow_val_next;
    logic [3:0]       shadow_dp_reg, shadow_dp_next;
    logic [3:0]       an_reg, an_next;
    logic [6:0]       seg_reg, seg_next;
    logic             dp_reg, dp_next;

    logic [3:0] digit_sel;
    logic [3:0] nibble;
    logic       slot_blank;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign digit_sel[gi] = (idx_reg == 2'(gi));
        end
    endgenerate

    assign nibble     = shadow_val_reg[{idx_reg, 2'b00} +: 4];
    assign slot_blank = (cnt_reg < BLANK_C) || (|(bus.blank & digit_sel));

    always_comb begin
        cnt_next        = cnt_reg + CNT_W'(1);
        idx_next        = idx_reg;
        shadow_val_next = shadow_val_reg;
        shadow_dp_next  = shadow_dp_reg;
        if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
            idx_next = idx_reg + 2'd1;
        end
        if (bus.load) begin
            shadow_val_next = bus.value;
            shadow_dp_next  = bus.dp_in;
        end
    end

    always_comb begin
        an_next = slot_blank ? 4'b1111 : ~digit_sel;
        dp_next = ~(|(shadow_dp_reg & digit_sel));
        seg_next = 7'b1111111;
        case (nibble)
            4'h0: seg_next = 7'b1000000;
            4'h1: seg_next = 7'b1111001;
            4'h2: seg_next = 7'b0100100;
            4'h3: seg_next = 7'b0110000;
            4'h4: seg_next = 7'b0011001;
            4'h5: seg_next = 7'b0010010;
            4'h6: seg_next = 7'b0000010;
            4'h7: seg_next = 7'b1111000;
            4'h8: seg_next = 7'b0000000;
            4'h9: seg_next = 7'b0010000;
            4'hA: seg_next = 7'b0001000;
            4'hB: seg_next = 7'b0000011;
            4'hC: seg_next = 7'b1000110;
            4'hD: seg_next = 7'b0100001;
            4'hE: seg_next = 7'b0000110;
            4'hF: seg_next = 7'b0001110;
            default: seg_next = 7'b1111111;
        endcase
    end

    // Outputs are registered from pre-edge state, giving one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            idx_reg        <= 2'd0;
            shadow_val_reg <= 16'h0000;
            shadow_dp_reg  <= 4'b0000;
            an_reg         <= 4'b1111;
            seg_reg        <= 7'b1111111;
            dp_reg         <= 1'b1;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            shadow_val_reg <= shadow_val_next;
            shadow_dp_reg  <= shadow_dp_next;
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
        end
    end

    assign bus.an  = an_reg;
    assign bus.seg = seg_reg;
    assign bus.dp  = dp_reg;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed and random checks of seven_seg_scan against a cycle-count based
// reference model (REFRESH_DIV=8, BLANK_CYC=2).
module tb_seven_seg_scan;
    localparam int RDIV  = 8;
    localparam int BLANK = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    // Model: time since reset in cycles, plus the captured display data.
    int          m_t   = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp  = '0;
    int          o_cnt = 0;
    int          o_idx = 0;
    logic [3:0]  prev_an = 4'b1111;

    seven_seg_scan_if bus();

    seven_seg_scan #(.REFRESH_DIV(RDIV), .BLANK_CYC(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_of(input int n);
        case (n)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            10: return 7'b0001000; 11: return 7'b0000011;
            12: return 7'b1000110; 13: return 7'b0100001;
            14: return 7'b0000110; default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict the registered outputs from the model, advance, compare.
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         nib;
        if (rst) begin
            e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
            m_t = 0; m_val = '0; m_dp = '0;
            o_cnt = -1; o_idx = -1;
        end else begin
            o_cnt = m_t % RDIV;
            o_idx = (m_t / RDIV) % 4;
            nib   = (int'(m_val) >> (4 * o_idx)) % 16;
            e_seg = hex_of(nib);
            e_dp  = ~m_dp[o_idx];
            e_an  = (o_cnt < BLANK || bus.blank[o_idx]) ? 4'b1111 : ~(4'b0001 << o_idx);
            if (bus.load) begin
                m_val = bus.value;
                m_dp  = bus.dp_in;
            end
            m_t++;
        end
        @(posedge clk);
        #1;
        chk("an", {4'h0, bus.an}, {4'h0, e_an});
        chk("seg", {1'b0, bus.seg}, {1'b0, e_seg});
        chk("dp", {7'h0, bus.dp}, {7'h0, e_dp});
        chk("an_onehot", 8'($countones(~bus.an) <= 1), 8'd1);
        chk("an_direct_switch",
            8'(prev_an != 4'b1111 && bus.an != 4'b1111 && prev_an != bus.an), 8'd0);
        prev_an = bus.an;
    endtask

    function automatic logic [6:0] pat2(input int idx);
        case (idx)
            0: return 7'b0001110;
            1: return 7'b0100100;
            2: return 7'b0000011;
            default: return 7'b0011001;
        endcase
    endfunction

    initial begin
        bus.value = '0; bus.load = 1'b0; bus.dp_in = '0; bus.blank = '0;

        // Reset state
        rst = 1'b1;
        step();
        chk("reset_an", {4'h0, bus.an}, 8'h0F);
        chk("reset_seg", {1'b0, bus.seg}, 8'h7F);
        step();
        rst = 1'b0;

        // 1: idle scan of zeros
        for (int i = 0; i < 4 * RDIV; i++) begin
            step();
            chk("t1_seg", {1'b0, bus.seg}, {1'b0, 7'b1000000});
        end

        // 2: one-cycle load of 4B2F with dp on digit 2
        bus.value = 16'h4B2F; bus.dp_in = 4'b0100; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 4 * RDIV; i++) begin
            step();
            chk("t2_seg", {1'b0, bus.seg}, {1'b0, pat2(o_idx)});
            chk("t2_dp", {7'h0, bus.dp}, {7'h0, (o_idx == 2) ? 1'b0 : 1'b1});
        end

        // 3: digit 1 blanked
        bus.value = 16'h1234; bus.dp_in = 4'b0000; bus.load = 1'b1; bus.blank = 4'b0010;
        step();
        bus.load = 1'b0;
        for (int i = 0; i < 4 * RDIV; i++) begin
            step();
            if (o_idx == 1) chk("t3_blank_an", {4'h0, bus.an}, 8'h0F);
        end
        bus.blank = 4'b0000;

        // 4: load on the cycle that wraps from digit 0 to digit 1
        begin
            int n = 0;
            while (!((m_t % RDIV) == RDIV - 1 && ((m_t / RDIV) % 4) == 0) && n < 64) begin
                step(); n++;
            end
            bus.value = 16'h9999; bus.load = 1'b1;
            step();
            bus.load = 1'b0;
            n = 0;
            while (bus.an !== 4'b1101 && n < 16) begin
                step(); n++;
            end
            chk("t4_d1_timeout", 8'(n < 16), 8'd1);
            chk("t4_d1_seg", {1'b0, bus.seg}, {1'b0, 7'b0010000});
        end

        // 5: reset mid-slot at cnt=4, idx=2
        begin
            int n = 0;
            while (!((m_t % RDIV) == 4 && ((m_t / RDIV) % 4) == 2) && n < 64) begin
                step(); n++;
            end
            chk("t5_align", 8'(n < 64), 8'd1);
            rst = 1'b1;
            step();
            chk("t5_rst_an", {4'h0, bus.an}, 8'h0F);
            chk("t5_rst_seg", {1'b0, bus.seg}, 8'h7F);
            chk("t5_rst_dp", {7'h0, bus.dp}, 8'h01);
            rst = 1'b0;
            for (int i = 0; i < RDIV; i++) begin
                step();
                chk("t5_restart_seg", {1'b0, bus.seg}, {1'b0, 7'b1000000});
                if (i >= BLANK) chk("t5_restart_an", {4'h0, bus.an}, 8'h0E);
            end
        end

        // 6: random traffic
        for (int i = 0; i < 1000; i++) begin
            bus.value = 16'($urandom);
            bus.dp_in = 4'($urandom);
            bus.load  = ($urandom_range(0, 3) == 0);
            bus.blank = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
